// File: rtl/edge_stream_packer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// edge_stream_packer: packs a thresholded edge pixel stream into 16-bit
// row-aligned words behind a first-word-fall-through output FIFO.  Rev 1.0
// ---------------------------------------------------------------------------
module edge_stream_packer #(
  parameter int          IMG_W      = 632,
  parameter int          IMG_H      = 504,
  parameter logic [15:0] EDGE_THR   = 16'd1,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic [15:0] out_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_eol,
  output logic        out_eof,
  output logic        frame_done,
  output logic        overflow,
  input  logic        clr_ovf,
  output logic [7:0]  frame_cnt
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [AW:0]   DEPTH    = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DONE = 2'd2} state_t;

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [3:0]    bit_idx;
  logic [15:0]   acc;
  logic [15:0]   acc_next;
  logic          edge_bit;
  logic          row_end;
  logic          word_end;
  logic          frame_end;

  // Closed word staged for one cycle before it enters the FIFO.
  logic          pend_valid;
  logic [15:0]   pend_word;
  logic          pend_eol;
  logic          pend_eof;

  assign edge_bit  = (in_data >= EDGE_THR);
  assign row_end   = (col == COL_LAST);
  assign word_end  = (bit_idx == 4'd15) || row_end;
  assign frame_end = in_valid && row_end && (row == ROW_LAST);

  always_comb begin
    acc_next          = (bit_idx == 4'd0) ? 16'h0000 : acc;
    acc_next[bit_idx] = edge_bit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      bit_idx    <= '0;
      acc        <= '0;
      pend_valid <= 1'b0;
      pend_word  <= '0;
      pend_eol   <= 1'b0;
      pend_eof   <= 1'b0;
    end else begin
      pend_valid <= in_valid && word_end;
      if (in_valid) begin
        acc <= acc_next;
        if (word_end) begin
          pend_word <= acc_next;
          pend_eol  <= row_end;
          pend_eof  <= row_end && (row == ROW_LAST);
          bit_idx   <= 4'd0;
        end else begin
          bit_idx   <= bit_idx + 4'd1;
        end
        if (row_end) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Counters wrap on the last pixel, so a pixel in the DONE cycle is
  // naturally col 0 / row 0 of the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= frame_end;
      if (frame_end) begin
        state     <= DONE;
        frame_cnt <= frame_cnt + 8'd1;
      end else if (in_valid) begin
        state <= ACTIVE;
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end

  logic [17:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [17:0]   head;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic          drop;

  assign full      = (count == DEPTH);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign push_ok   = pend_valid && (!full || pop);
  assign drop      = pend_valid && full && !pop;
  assign head      = mem[rd_ptr];
  assign out_word  = out_valid ? head[15:0] : 16'h0000;
  assign out_eol   = out_valid && head[16];
  assign out_eof   = out_valid && head[17];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= {pend_eof, pend_eol, pend_word};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A new drop outranks a simultaneous clear.
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_edge_stream_packer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_edge_stream_packer: directed self-checking bench for edge_stream_packer.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_edge_stream_packer;

  localparam int W = 632;
  localparam int H = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic [15:0] out_word;
  logic        out_valid;
  logic        out_ready;
  logic        out_eol;
  logic        out_eof;
  logic        frame_done;
  logic        overflow;
  logic        clr_ovf;
  logic [7:0]  frame_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int fd_cnt = 0;
  logic [17:0] q[$];

  edge_stream_packer #(
    .IMG_W(W), .IMG_H(H), .EDGE_THR(16'd1), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready),
    .out_eol(out_eol), .out_eof(out_eof), .frame_done(frame_done),
    .overflow(overflow), .clr_ovf(clr_ovf), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Record every handshake and frame_done cycle away from the active edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) q.push_back({out_eof, out_eol, out_word});
    if (!rst && frame_done) fd_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 16'h0000;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_data  = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
    in_data = 16'h0000;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic qword(input string tag, input int idx, input logic [17:0] exp);
    if (idx < q.size()) check_val(tag, 32'(q[idx]), 32'(exp));
    else                check_val(tag, 32'hDEAD_BEEF, 32'(exp));
  endtask

  initial begin
    int bad_words;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; clr_ovf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_out_word", 32'(out_word), 32'd0);
    check_val("rst_tags", 32'({out_eol, out_eof, frame_done}), 32'd0);
    check_val("rst_overflow", 32'(overflow), 32'd0);
    check_val("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    rst = 1'b0;

    // Frame of alternating 255/0 pixels.
    q.delete(); fd_cnt = 0;
    for (int p = 0; p < W * H; p++) send((p % 2 == 0) ? 16'd255 : 16'd0);
    idle(10);
    check_val("alt_count", q.size(), 80);
    bad_words = 0;
    for (int i = 0; i < q.size(); i++) begin
      if ((i % 40) == 39) begin
        if (q[i] != {(i == 79), 1'b1, 16'h0055}) bad_words++;
      end else if (q[i] != {2'b00, 16'h5555}) bad_words++;
    end
    check_val("alt_bad_words", bad_words, 0);
    qword("alt_w38", 38, {2'b00, 16'h5555});
    qword("alt_w39", 39, {2'b01, 16'h0055});
    qword("alt_w79", 79, {2'b11, 16'h0055});
    check_val("alt_frame_done", fd_cnt, 1);
    check_val("alt_frame_cnt", 32'(frame_cnt), 32'd1);

    // Threshold boundary 0 vs 1 with idle gaps mid-word, then no gaps.
    q.delete();
    for (int k = 0; k < 16; k++) begin
      send((k % 3 == 0) ? 16'd1 : 16'd0);
      if (k == 5 || k == 10) idle(2);
    end
    for (int k = 0; k < 16; k++) send((k % 3 == 0) ? 16'd1 : 16'd0);
    idle(5);
    check_val("thr_count", q.size(), 2);
    qword("thr_gap_word", 0, {2'b00, 16'h9249});
    qword("thr_nogap_word", 1, {2'b00, 16'h9249});

    // Five words with out_ready low: four kept, fifth dropped.
    q.delete();
    out_ready = 1'b0;
    for (int j = 0; j < 5; j++)
      for (int k = 0; k < 16; k++) send((k == j) ? 16'd1 : 16'd0);
    idle(4);
    check_val("ovf_set", 32'(overflow), 32'd1);
    check_val("ovf_head", 32'({out_valid, out_word}), 32'h1_0001);
    clr_ovf = 1'b1;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    check_val("ovf_clear", 32'(overflow), 32'd0);
    out_ready = 1'b1;
    idle(8);
    check_val("ovf_kept", q.size(), 4);
    for (int j = 0; j < 4; j++) qword($sformatf("ovf_w%0d", j), j, {2'b00, 16'(1 << j)});

    // Full FIFO with a pop in the push cycle: nothing dropped.
    q.delete();
    out_ready = 1'b0;
    for (int j = 0; j < 5; j++)
      for (int k = 0; k < 16; k++) send((k == j + 8) ? 16'd1 : 16'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    idle(3);
    check_val("full_pop_ovf", 32'(overflow), 32'd0);
    check_val("full_pop_popped", q.size(), 1);
    out_ready = 1'b1;
    idle(8);
    check_val("full_pop_total", q.size(), 5);
    for (int j = 0; j < 5; j++) qword($sformatf("full_pop_w%0d", j), j, {2'b00, 16'(1 << (j + 8))});

    // Reset mid-frame with data pending.
    out_ready = 1'b0;
    for (int k = 0; k < 16; k++) send(16'd7);
    for (int k = 0; k < 5; k++) send(16'd0);
    idle(2);
    check_val("pre_rst_valid", 32'(out_valid), 32'd1);
    pulse_rst();
    check_val("post_rst_valid", 32'(out_valid), 32'd0);
    check_val("post_rst_word", 32'(out_word), 32'd0);
    check_val("post_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    out_ready = 1'b1;
    q.delete(); fd_cnt = 0;
    for (int p = 0; p < W * H; p++) send(16'h8000);
    idle(10);
    check_val("rst_frame_count", q.size(), 40 * H);
    qword("rst_frame_w0", 0, {2'b00, 16'hFFFF});
    qword("rst_frame_w39", 39, {2'b01, 16'h00FF});
    qword("rst_frame_w79", 79, {2'b11, 16'h00FF});
    check_val("rst_frame_done", fd_cnt, 1);
    check_val("rst_frame_cnt", 32'(frame_cnt), 32'd1);

    // Back-to-back frames; frame 2 pixel 0 arrives in the DONE cycle.
    pulse_rst();
    q.delete(); fd_cnt = 0;
    in_valid = 1'b1;
    for (int p = 0; p < 2 * W * H; p++) begin
      in_data = (p < W * H) ? 16'd1 : (((p - W * H) % 2 == 1) ? 16'd255 : 16'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    idle(10);
    check_val("b2b_count", q.size(), 160);
    qword("b2b_f1_last", 79, {2'b11, 16'h00FF});
    qword("b2b_f2_w0", 80, {2'b00, 16'hAAAA});
    qword("b2b_f2_w39", 119, {2'b01, 16'h00AA});
    qword("b2b_f2_last", 159, {2'b11, 16'h00AA});
    check_val("b2b_frame_done", fd_cnt, 2);
    check_val("b2b_frame_cnt", 32'(frame_cnt), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
